// File: rtl/rc4_stream_encryptor.sv
// Streaming RC4 encryptor: builds and key-schedules an external 256-byte S-memory,
// then XORs plaintext with keystream. Optional build macro: RC4_CHECKSUM_EN.
module rc4_stream_encryptor #(
    parameter int MSG_LEN = 32
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic        start,
    input  logic [23:0] secret_key,
    input  logic [7:0]  pt_data,
    input  logic        pt_valid,
    output logic        pt_ready,
    output logic [7:0]  ct_data,
    output logic        ct_valid,
    input  logic        ct_ready,
    output logic [7:0]  s_addr,
    output logic [7:0]  s_wdata,
    output logic        s_wren,
    input  logic [7:0]  s_rdata,
    output logic        busy,
`ifdef RC4_CHECKSUM_EN
    output logic [7:0]  checksum,
`endif
    output logic        done
);

    // state | meaning
    // IDLE  | waiting for start
    // INIT  | S[i] = i sweep
    // K_RI  | KSA: read S[i]          K_WI  | KSA: read latency
    // K_RJ  | KSA: take si, read S[j] K_WJ  | KSA: read latency
    // K_WRJ | KSA: take sj, S[j]=si   K_WRI | KSA: S[i]=sj
    // P_RI  | PRGA: i++, read S[i]    P_WI  | PRGA: read latency
    // P_RJ  | PRGA: take si, read S[j] P_WJ | PRGA: read latency
    // P_WRJ | PRGA: take sj, S[j]=si  P_WRI | PRGA: S[i]=sj
    // P_RF  | PRGA: read S[si+sj]     P_WF  | PRGA: read latency
    // P_PT  | waiting for plaintext   P_CT  | presenting ciphertext
    // DONE  | one-cycle completion pulse
    typedef enum logic [4:0] {
        IDLE, INIT, K_RI, K_WI, K_RJ, K_WJ, K_WRJ, K_WRI,
        P_RI, P_WI, P_RJ, P_WJ, P_WRJ, P_WRI, P_RF, P_WF,
        P_PT, P_CT, DONE
    } state_t;

    localparam logic [7:0] MSG_LEN_B = 8'(MSG_LEN);

    state_t      state_q, state_d;
    logic [23:0] key_q, key_d;
    logic [7:0]  i_q, i_d, j_q, j_d;
    logic [7:0]  si_q, si_d, sj_q, sj_d, f_q, f_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  kidx_q, kidx_d;
    logic        pt_ready_d, ct_valid_d, s_wren_d, busy_d, done_d;
    logic [7:0]  ct_data_d, s_addr_d, s_wdata_d;
    logic [7:0]  key_byte, i_inc, cnt_inc, j_ksa, j_prga;
`ifdef RC4_CHECKSUM_EN
    logic [7:0]  chk_q, chk_d;
    assign checksum = chk_q;
`endif

    // kidx tracks i mod 3 so no divider is needed
    always_comb begin
        case (kidx_q)
            2'd0:    key_byte = key_q[23:16];
            2'd1:    key_byte = key_q[15:8];
            default: key_byte = key_q[7:0];
        endcase
    end

    assign i_inc   = i_q + 8'd1;
    assign cnt_inc = cnt_q + 8'd1;
    assign j_ksa   = j_q + s_rdata + key_byte;
    assign j_prga  = j_q + s_rdata;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            key_q    <= '0;
            i_q      <= '0;
            j_q      <= '0;
            si_q     <= '0;
            sj_q     <= '0;
            f_q      <= '0;
            cnt_q    <= '0;
            kidx_q   <= '0;
            pt_ready <= 1'b0;
            ct_valid <= 1'b0;
            ct_data  <= '0;
            s_addr   <= '0;
            s_wdata  <= '0;
            s_wren   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef RC4_CHECKSUM_EN
            chk_q    <= '0;
`endif
        end else begin
            key_q    <= key_d;
            i_q      <= i_d;
            j_q      <= j_d;
            si_q     <= si_d;
            sj_q     <= sj_d;
            f_q      <= f_d;
            cnt_q    <= cnt_d;
            kidx_q   <= kidx_d;
            pt_ready <= pt_ready_d;
            ct_valid <= ct_valid_d;
            ct_data  <= ct_data_d;
            s_addr   <= s_addr_d;
            s_wdata  <= s_wdata_d;
            s_wren   <= s_wren_d;
            busy     <= busy_d;
            done     <= done_d;
`ifdef RC4_CHECKSUM_EN
            chk_q    <= chk_d;
`endif
        end
    end

    // Outputs are registered with the values belonging to the state being entered.
    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        i_d        = i_q;
        j_d        = j_q;
        si_d       = si_q;
        sj_d       = sj_q;
        f_d        = f_q;
        cnt_d      = cnt_q;
        kidx_d     = kidx_q;
        pt_ready_d = pt_ready;
        ct_valid_d = ct_valid;
        ct_data_d  = ct_data;
        s_addr_d   = s_addr;
        s_wdata_d  = s_wdata;
        s_wren_d   = s_wren;
        busy_d     = busy;
        done_d     = 1'b0;
`ifdef RC4_CHECKSUM_EN
        chk_d      = chk_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d     = secret_key;
                    i_d       = '0;
                    j_d       = '0;
                    cnt_d     = '0;
                    kidx_d    = '0;
                    busy_d    = 1'b1;
                    s_addr_d  = '0;
                    s_wdata_d = '0;
                    s_wren_d  = 1'b1;
`ifdef RC4_CHECKSUM_EN
                    chk_d     = '0;
`endif
                    state_d   = INIT;
                end
            end
            INIT: begin
                if (i_q == 8'd255) begin
                    i_d      = '0;
                    j_d      = '0;
                    kidx_d   = '0;
                    s_wren_d = 1'b0;
                    s_addr_d = '0;
                    state_d  = K_RI;
                end else begin
                    i_d       = i_inc;
                    s_addr_d  = i_inc;
                    s_wdata_d = i_inc;
                end
            end
            K_RI: state_d = K_WI;
            K_WI: begin
                si_d     = s_rdata;
                j_d      = j_ksa;
                s_addr_d = j_ksa;
                state_d  = K_RJ;
            end
            K_RJ: state_d = K_WJ;
            K_WJ: begin
                sj_d      = s_rdata;
                s_addr_d  = j_q;
                s_wdata_d = si_q;
                s_wren_d  = 1'b1;
                state_d   = K_WRJ;
            end
            K_WRJ: begin
                s_addr_d  = i_q;
                s_wdata_d = sj_q;
                state_d   = K_WRI;
            end
            K_WRI: begin
                s_wren_d = 1'b0;
                if (i_q == 8'd255) begin
                    // i wraps to 0 and PRGA immediately pre-increments it
                    i_d      = 8'd1;
                    j_d      = '0;
                    s_addr_d = 8'd1;
                    state_d  = P_RI;
                end else begin
                    i_d      = i_inc;
                    s_addr_d = i_inc;
                    kidx_d   = (kidx_q == 2'd2) ? 2'd0 : kidx_q + 2'd1;
                    state_d  = K_RI;
                end
            end
            P_RI: state_d = P_WI;
            P_WI: begin
                si_d     = s_rdata;
                j_d      = j_prga;
                s_addr_d = j_prga;
                state_d  = P_RJ;
            end
            P_RJ: state_d = P_WJ;
            P_WJ: begin
                sj_d      = s_rdata;
                s_addr_d  = j_q;
                s_wdata_d = si_q;
                s_wren_d  = 1'b1;
                state_d   = P_WRJ;
            end
            P_WRJ: begin
                s_addr_d  = i_q;
                s_wdata_d = sj_q;
                state_d   = P_WRI;
            end
            P_WRI: begin
                s_wren_d = 1'b0;
                s_addr_d = si_q + sj_q;
                state_d  = P_RF;
            end
            P_RF: state_d = P_WF;
            P_WF: begin
                f_d        = s_rdata;
                pt_ready_d = 1'b1;
                state_d    = P_PT;
            end
            P_PT: begin
                if (pt_valid) begin
                    ct_data_d  = pt_data ^ f_q;
                    ct_valid_d = 1'b1;
                    pt_ready_d = 1'b0;
                    state_d    = P_CT;
                end
            end
            P_CT: begin
                if (ct_ready) begin
                    ct_valid_d = 1'b0;
                    cnt_d      = cnt_inc;
`ifdef RC4_CHECKSUM_EN
                    chk_d      = chk_q ^ ct_data;
`endif
                    if (cnt_inc == MSG_LEN_B) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        i_d      = i_inc;
                        s_addr_d = i_inc;
                        state_d  = P_RI;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule
